// File: rtl/servo_pwm_decoder.sv
// RC-servo PWM receiver: measures the high time of pwm_in and converts it back
// to the 8-bit position code, flagging malformed pulses and loss of signal.
module servo_pwm_decoder #(
    parameter int MIN_CLKS       = 100000,
    parameter int TICK_CLKS      = 393,
    parameter int MAX_CODE       = 254,
    parameter int VALID_MIN_CLKS = 80000,
    parameter int VALID_MAX_CLKS = 220000,
    parameter int TIMEOUT_CLKS   = 2500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pwm_in,
    output logic [7:0]  position,
    output logic        position_valid,
    output logic [17:0] pulse_width,
    output logic        pulse_error,
    output logic        signal_lost
);

    localparam int PRE_W = (TICK_CLKS > 1) ? $clog2(TICK_CLKS) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [17:0]      MIN_V    = 18'(MIN_CLKS);
    localparam logic [17:0]      VMIN_V   = 18'(VALID_MIN_CLKS);
    localparam logic [17:0]      VMAX_V   = 18'(VALID_MAX_CLKS);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CLKS - 1);
    localparam logic [TO_W-1:0]  TO_V     = TO_W'(TIMEOUT_CLKS);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]       CODE_MAX = 8'(MAX_CODE);

    typedef enum logic [1:0] {WAIT_LOW, IDLE, HIGH} state_t;

    function automatic logic [17:0] width_inc(input logic [17:0] w);
        return (w == 18'h3FFFF) ? w : w + 18'd1;
    endfunction

    function automatic logic [7:0] code_inc(input logic [7:0] c);
        return (c >= CODE_MAX) ? CODE_MAX : c + 8'd1;
    endfunction

    state_t           state;
    logic             sync_p0;
    logic             s;
    logic             s_d;
    logic             rise;
    logic             fall;
    logic [17:0]      width_cnt;
    logic [17:0]      width_next;
    logic [PRE_W-1:0] presc;
    logic [7:0]       acc;
    logic [TO_W-1:0]  to_cnt;

    assign rise       = s & ~s_d;
    assign fall       = ~s & s_d;
    assign width_next = width_inc(width_cnt);

    // Synchronizer resets to 1 so a line already high at reset release shows
    // no rise and WAIT_LOW holds until a genuine low is seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0        <= 1'b1;
            s              <= 1'b1;
            s_d            <= 1'b1;
            state          <= WAIT_LOW;
            width_cnt      <= '0;
            presc          <= '0;
            acc            <= '0;
            to_cnt         <= '0;
            position       <= '0;
            pulse_width    <= '0;
            position_valid <= 1'b0;
            pulse_error    <= 1'b0;
            signal_lost    <= 1'b1;
        end else begin
            sync_p0        <= pwm_in;
            s              <= sync_p0;
            s_d            <= s;
            position_valid <= 1'b0;
            pulse_error    <= 1'b0;

            if (rise) begin
                to_cnt <= '0;
            end else if (to_cnt != TO_V) begin
                to_cnt <= to_cnt + 1'b1;
                if (to_cnt == TO_LAST) signal_lost <= 1'b1;
            end

            case (state)
                WAIT_LOW: begin
                    if (!s) state <= IDLE;
                end
                IDLE: begin
                    if (rise) begin
                        state     <= HIGH;
                        width_cnt <= 18'd1;
                        presc     <= '0;
                        acc       <= '0;
                    end
                end
                HIGH: begin
                    if (s) begin
                        if (width_cnt >= VMAX_V) begin
                            pulse_error <= 1'b1;
                            state       <= WAIT_LOW;
                        end else begin
                            width_cnt <= width_next;
                            // Each TICK_CLKS clocks beyond MIN_CLKS adds one code LSB.
                            if (width_next > MIN_V) begin
                                if (presc == PRE_LAST) begin
                                    presc <= '0;
                                    acc   <= code_inc(acc);
                                end else begin
                                    presc <= presc + 1'b1;
                                end
                            end
                        end
                    end else if (fall) begin
                        state <= IDLE;
                        if (width_cnt < VMIN_V) begin
                            pulse_error <= 1'b1;
                        end else begin
                            position       <= acc;
                            pulse_width    <= width_cnt;
                            position_valid <= 1'b1;
                            signal_lost    <= 1'b0;
                        end
                    end
                end
                default: state <= WAIT_LOW;
            endcase
        end
    end

endmodule
